// File: rtl/move_link_pkg.sv
// Shared types and constants for the UART game-move link.
// Move byte layout is {MOVE_HDR, square index}.
package move_link_pkg;

    localparam logic MODE_SENDING   = 1'b0;
    localparam logic MODE_RECEIVING = 1'b1;

    localparam logic [3:0] MOVE_HDR   = 4'hA;
    localparam logic [3:0] MAX_SQUARE = 4'd8;

    typedef enum logic [3:0] {
        IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        RX_WAIT,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_CHECK,
        DONE,
        HOLD
    } link_state_t;

    function automatic logic [7:0] move_byte(input logic [3:0] idx);
        return {MOVE_HDR, idx};
    endfunction

    function automatic logic move_ok(input logic [7:0] b);
        return (b[7:4] == MOVE_HDR) && (b[3:0] <= MAX_SQUARE);
    endfunction

endpackage

// File: rtl/uart_move_link_if.sv
// Request, move and serial-line bundle between control FSM and move link.
// master = control/board side, slave = uart_move_link.
interface uart_move_link_if;

    logic       uart_en;
    logic       uart_mode;
    logic [3:0] move_in;
    logic       rx;
    logic       tx;
    logic       rx_tx_done;
    logic [3:0] move_out;
    logic       move_valid;
    logic       frame_err;

    modport master (
        output uart_en, uart_mode, move_in, rx,
        input  tx, rx_tx_done, move_out, move_valid, frame_err
    );

    modport slave (
        input  uart_en, uart_mode, move_in, rx,
        output tx, rx_tx_done, move_out, move_valid, frame_err
    );

endinterface

// File: rtl/uart_tick_gen.sv
// Oversample tick divider; restart holds the phase at zero so the
// first tick lands exactly DIV cycles after restart releases.
module uart_tick_gen #(
    parameter int DIV = 423
) (
    input  logic pclk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = !restart && (cnt == LAST);

    always_ff @(posedge pclk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_move_link.sv
// Serial end of the game-move link: 8N1 move TX and validated move RX.
// Define MOVE_LINK_CHECKSUM_EN to follow each move byte with its complement.
import move_link_pkg::*;

module uart_move_link #(
    parameter int CLK_HZ     = 65_000_000,
    parameter int BAUD       = 9_600,
    parameter int OVERSAMPLE = 16
) (
    input logic             pclk,
    input logic             rst,
    uart_move_link_if.slave link
);

    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);

    link_state_t state_q;
    link_state_t state_d;

    logic          cur_mode;
    logic          tick;
    logic          restart;
    logic [TW-1:0] tcnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    sh;
    logic          rx_s1;
    logic          rx_s2;
    logic          rx_prev;
    logic          rx_fall;
    logic          bit_end;
    logic          half_end;
    logic          busy;
    logic          start;
    logic          more;
    logic          frame_ok;
    logic          rx_err;
    logic [3:0]    rx_move;
    logic [7:0]    next_byte;
    logic          tx_d;
    logic          tx_q;
    logic          done_q;
    logic          valid_q;
    logic          err_q;
    logic [3:0]    move_q;

`ifdef MOVE_LINK_CHECKSUM_EN
    logic       second;
    logic [7:0] byte1;

    assign more      = !second;
    assign frame_ok  = move_ok(byte1) && (sh == ~byte1);
    assign rx_move   = byte1[3:0];
    assign next_byte = ~byte1;

    always_ff @(posedge pclk) begin
        if (rst) begin
            second <= 1'b0;
            byte1  <= '0;
        end else if (start) begin
            second <= 1'b0;
            byte1  <= move_byte(link.move_in);
        end else if (state_q == TX_STOP && state_d == TX_START) begin
            second <= 1'b1;
        end else if (state_q == RX_STOP && state_d == RX_WAIT && !rx_err) begin
            second <= 1'b1;
            byte1  <= sh;
        end else if (rx_err) begin
            second <= 1'b0;
        end
    end
`else
    assign more      = 1'b0;
    assign frame_ok  = move_ok(sh);
    assign rx_move   = sh[3:0];
    assign next_byte = 8'hFF;
`endif

    assign restart  = state_q inside {IDLE, RX_WAIT, RX_CHECK, DONE, HOLD};
    assign bit_end  = tick && (tcnt == T_LAST);
    assign half_end = tick && (tcnt == T_HALF);
    assign rx_fall  = rx_prev && !rx_s2;
    assign busy     = !(state_q inside {IDLE, DONE, HOLD});
    assign start    = (state_q == IDLE) && link.uart_en;

    uart_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .pclk   (pclk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rx_err  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (link.uart_en) begin
                    state_d = (link.uart_mode == MODE_RECEIVING) ? RX_WAIT : TX_START;
                end
            end
            TX_START: if (bit_end) state_d = TX_DATA;
            TX_DATA:  if (bit_end && bit_cnt == 3'd7) state_d = TX_STOP;
            TX_STOP:  if (bit_end) state_d = more ? TX_START : DONE;
            RX_WAIT:  if (rx_fall) state_d = RX_START;
            RX_START: if (half_end) state_d = rx_s2 ? RX_WAIT : RX_DATA;
            RX_DATA:  if (bit_end && bit_cnt == 3'd7) state_d = RX_STOP;
            RX_STOP: begin
                if (bit_end) begin
                    if (!rx_s2) begin
                        rx_err  = 1'b1;
                        state_d = RX_WAIT;
                    end else begin
                        state_d = more ? RX_WAIT : RX_CHECK;
                    end
                end
            end
            RX_CHECK: begin
                if (frame_ok) begin
                    state_d = DONE;
                end else begin
                    rx_err  = 1'b1;
                    state_d = RX_WAIT;
                end
            end
            DONE: state_d = HOLD;
            HOLD: begin
                if (!link.uart_en || link.uart_mode != cur_mode) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Dropping the request abandons any frame in flight silently.
        if (busy && !link.uart_en) begin
            state_d = IDLE;
            rx_err  = 1'b0;
        end
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (1'b1)
            state_q == TX_START: tx_d = 1'b0;
            state_q == TX_DATA:  tx_d = sh[0];
            default: ;
        endcase
        if (!link.uart_en) tx_d = 1'b1;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            cur_mode <= MODE_SENDING;
            tcnt     <= '0;
            bit_cnt  <= '0;
            sh       <= '0;
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            move_q   <= '0;
        end else begin
            rx_s1   <= link.rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            tx_q    <= tx_d;
            done_q  <= (state_q == DONE);
            valid_q <= (state_q == DONE) && (cur_mode == MODE_RECEIVING);
            err_q   <= rx_err;

            if (state_d != state_q) begin
                tcnt <= '0;
            end else if (tick) begin
                tcnt <= (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
            end

            if (state_q != TX_DATA && state_q != RX_DATA) begin
                bit_cnt <= '0;
            end else if (bit_end) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            // One shift register serves both directions, LSB first.
            if (start) begin
                cur_mode <= link.uart_mode;
                sh       <= move_byte(link.move_in);
            end else if (state_q == TX_STOP && state_d == TX_START) begin
                sh <= next_byte;
            end else if (bit_end && state_q == TX_DATA) begin
                sh <= {1'b1, sh[7:1]};
            end else if (bit_end && state_q == RX_DATA) begin
                sh <= {rx_s2, sh[7:1]};
            end

            if (state_q == RX_CHECK && state_d == DONE) begin
                move_q <= rx_move;
            end
        end
    end

    assign link.tx         = tx_q;
    assign link.rx_tx_done = done_q;
    assign link.move_valid = valid_q;
    assign link.frame_err  = err_q;
    assign link.move_out   = move_q;

endmodule

// File: tb/tb_uart_move_link.sv
// Scoreboard bench for uart_move_link: directed TX/RX move frames.
// Also builds with MOVE_LINK_CHECKSUM_EN for the two-byte variant.
`timescale 1ns/1ps
module tb_uart_move_link;

    localparam int BIT = 160;
`ifdef MOVE_LINK_CHECKSUM_EN
    localparam int NBITS = 20;
    localparam int LAT   = 3202;
`else
    localparam int NBITS = 10;
    localparam int LAT   = 1602;
`endif

    localparam int K_TX  = 0;
    localparam int K_RX  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int         kind;
        logic [3:0] mv;
        int         at;
    } exp_t;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    uart_move_link_if link();

    uart_move_link #(
        .CLK_HZ    (1_600_000),
        .BAUD      (10_000),
        .OVERSAMPLE(16)
    ) dut (
        .pclk(pclk),
        .rst (rst),
        .link(link)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge pclk) begin
        exp_t e;
        logic bad;
        if (!rst && (link.rx_tx_done || link.frame_err || link.move_valid)) begin
            checks = checks + 1;
            if (q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_pulse cyc=%0d done=%b valid=%b err=%b",
                         cyc, link.rx_tx_done, link.move_valid, link.frame_err);
            end else begin
                e   = q.pop_front();
                bad = 1'b0;
                if (link.rx_tx_done != (e.kind != K_ERR)) bad = 1'b1;
                if (link.move_valid != (e.kind == K_RX)) bad = 1'b1;
                if (link.frame_err != (e.kind == K_ERR)) bad = 1'b1;
                if (link.move_out != e.mv) bad = 1'b1;
                if (e.at >= 0 && cyc != e.at) bad = 1'b1;
                if (bad) begin
                    errors = errors + 1;
                    $display("FAIL event got done=%b valid=%b err=%b move=%0d cyc=%0d want kind=%0d move=%0d cyc=%0d",
                             link.rx_tx_done, link.move_valid, link.frame_err,
                             link.move_out, cyc, e.kind, e.mv, e.at);
                end
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [3:0] mv, input int at);
        exp_t e;
        e.kind = kind;
        e.mv   = mv;
        e.at   = at;
        q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge pclk);
            n++;
        end
        #1;
        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s pending=%0d want=0", name, q.size());
            q.delete();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        link.rx = 1'b0;
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            link.rx = b[i];
            hold(BIT);
        end
        link.rx = stop;
        hold(BIT);
        link.rx = 1'b1;
        hold(20);
    endtask

    task automatic send_move(input logic [7:0] b);
        send_frame(b, 1'b1);
`ifdef MOVE_LINK_CHECKSUM_EN
        send_frame(~b, 1'b1);
`endif
    endtask

    task automatic rearm();
        link.uart_en = 1'b0;
        hold(2);
        link.uart_en = 1'b1;
        hold(2);
    endtask

    initial begin
        logic txv [0:19];
        int   n0;
        int   lows;
`ifdef MOVE_LINK_CHECKSUM_EN
        txv = '{0,1,1,0,0,0,1,0,1,1, 0,0,0,1,1,1,0,1,0,1};
`else
        txv = '{0,0,0,1,0,0,1,0,1,1, 1,1,1,1,1,1,1,1,1,1};
`endif
        link.uart_en   = 1'b0;
        link.uart_mode = 1'b0;
        link.move_in   = 4'd0;
        link.rx        = 1'b1;

        hold(3);
        check("reset_tx", link.tx, 1);
        check("reset_done", link.rx_tx_done, 0);
        check("reset_move_out", link.move_out, 0);
        check("reset_valid", link.move_valid, 0);
        check("reset_err", link.frame_err, 0);
        rst = 1'b0;
        hold(2);

`ifdef MOVE_LINK_CHECKSUM_EN
        link.move_in = 4'd3;
`else
        link.move_in = 4'd4;
`endif
        n0 = cyc;
        expect_ev(K_TX, 4'd0, n0 + LAT);
        link.uart_en = 1'b1;
        hold(2 + BIT / 2);
        for (int k = 0; k < NBITS; k++) begin
            check($sformatf("tx_bit%0d", k), link.tx, txv[k]);
            if (k == 3) link.move_in = 4'hF;
            if (k < NBITS - 1) hold(BIT);
        end
        wait_drain("tx_done", 400);

        link.uart_mode = 1'b1;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            hold(1);
            if (link.tx == 1'b0) lows++;
        end
        check("no_tx_repeat", lows, 0);

        expect_ev(K_RX, 4'd7, -1);
        send_move(8'hA7);
        wait_drain("rx_a7", 300);

        rearm();
        expect_ev(K_ERR, 4'd7, -1);
        send_move(8'hA9);
        wait_drain("err_index9", 300);
        expect_ev(K_ERR, 4'd7, -1);
        send_move(8'h57);
        wait_drain("err_header", 300);
        expect_ev(K_ERR, 4'd7, -1);
        send_frame(8'hA1, 1'b0);
        wait_drain("err_stop", 300);
        check("move_hold", link.move_out, 7);

        expect_ev(K_RX, 4'd2, -1);
        send_move(8'hA2);
        wait_drain("rx_a2", 300);

        rearm();
        link.rx = 1'b0;
        hold(40);
        link.rx = 1'b1;
        hold(400);
        expect_ev(K_RX, 4'd8, -1);
        send_move(8'hA8);
        wait_drain("rx_a8", 300);

`ifdef MOVE_LINK_CHECKSUM_EN
        rearm();
        expect_ev(K_ERR, 4'd8, -1);
        send_frame(8'hA3, 1'b1);
        send_frame(8'h5D, 1'b1);
        wait_drain("ck_mismatch", 300);
        expect_ev(K_RX, 4'd3, -1);
        send_frame(8'hA3, 1'b1);
        send_frame(8'h5C, 1'b1);
        wait_drain("ck_rx3", 300);
`endif

        link.uart_en = 1'b0;
        hold(4);
        link.uart_mode = 1'b0;
        link.move_in   = 4'd5;
        link.uart_en   = 1'b1;
        hold(500);
        rst          = 1'b1;
        link.uart_en = 1'b0;
        hold(1);
        check("rst_tx_high", link.tx, 1);
        check("rst_move_out", link.move_out, 0);
        hold(2);
        rst = 1'b0;
        hold(2000);
        check("idle_tx_high", link.tx, 1);

        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL final_queue pending=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
